mem_access_unit: RTL and testbench

Load/store unit for the memory stage of the barrel RISC-V pipeline. Consumes the M-stage control and data produced by the execute→memory pipeline register. Drives a single-port data-memory request/acknowledge interface and holds the pipeline with `stall_m` until the access completes. Returns extended load data and a gated register-write flag to the memory→writeback register.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// funct3 encodings, result-source select and FSM state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte/half replication with strobes,
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            byte_off,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << byte_off;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {byte_off[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = rdata[{byte_off, 3'b000} +: 8];
    lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
      F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane_byte};
      F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: fault detection, request/ack FSM that
// stalls the pipeline until the data-memory access completes.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BITS_THREADS  = 3
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     reg_write_m,
  input  logic                     mem_write_m,
  input  logic [1:0]               result_src_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
  input  logic [DATA_WIDTH-1:0]    write_data_m,
  input  logic [BITS_THREADS-1:0]  tid_m,
  output logic                     stall_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic                     reg_write_ok_m,
  output logic                     fault_m,
  output logic [BITS_THREADS-1:0]  fault_tid_m,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_wstrb,
  input  logic                     dmem_ack,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata
);

  lsu_state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
  logic                      fault_q, fault_d;
  logic [BITS_THREADS-1:0]   fault_tid_q, fault_tid_d;

  logic                      is_store, is_load, mem_op;
  logic                      misaligned, illegal, fault, req;
  logic [DATA_WIDTH-1:0]     lane_wdata, load_data;
  logic [3:0]                lane_wstrb;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (funct3_m),
    .byte_off   (alu_result_m[1:0]),
    .store_data (write_data_m),
    .rdata      (dmem_rdata),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (load_data)
  );

  // A store wins when both store and load-result select are set.
  always_comb begin
    is_store   = mem_write_m;
    is_load    = !mem_write_m && (result_src_m == RESULT_SRC_MEM);
    mem_op     = is_store || is_load;
    misaligned = ((funct3_m[1:0] == 2'b01) && alu_result_m[0]) ||
                 ((funct3_m[1:0] == 2'b10) && (alu_result_m[1:0] != 2'b00));
    illegal    = is_load ? (funct3_m inside {3'b011, 3'b110, 3'b111})
                         : !(funct3_m inside {F3_SB, F3_SH, F3_SW});
    fault      = mem_op && (misaligned || illegal);
    req        = mem_op && !fault && (state_q != ST_DONE) && !clr;
  end

  always_comb begin
    stall_m        = mem_op && !fault && (state_q != ST_DONE);
    reg_write_ok_m = reg_write_m && !fault;
    dmem_req       = req;
    dmem_we        = req && is_store;
    dmem_addr      = req ? {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00} : '0;
    dmem_wdata     = (req && is_store) ? lane_wdata : '0;
    dmem_wstrb     = (req && is_store) ? lane_wstrb : 4'b0000;
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    fault_d     = (state_q == ST_IDLE) && fault;
    fault_tid_d = fault_d ? tid_m : fault_tid_q;
    case (state_q)
      ST_IDLE: if (req) state_d = dmem_ack ? ST_DONE : ST_WAIT;
      ST_WAIT: if (dmem_ack) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A stale ack with no request outstanding never updates load data.
    if (req && dmem_ack && is_load) read_data_d = load_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      read_data_q <= '0;
      fault_q     <= 1'b0;
      fault_tid_q <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
      fault_tid_q <= fault_tid_d;
    end
  end

  assign read_data_m = read_data_q;
  assign fault_m     = fault_q;
  assign fault_tid_m = fault_tid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed
// expectations for stores, loads, faults, flush and non-memory ops.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [2:0]  tid_m;
  logic        stall_m, reg_write_ok_m, fault_m;
  logic [31:0] read_data_m;
  logic [2:0]  fault_tid_m;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk            (clk),
    .clr            (clr),
    .reg_write_m    (reg_write_m),
    .mem_write_m    (mem_write_m),
    .result_src_m   (result_src_m),
    .funct3_m       (funct3_m),
    .alu_result_m   (alu_result_m),
    .write_data_m   (write_data_m),
    .tid_m          (tid_m),
    .stall_m        (stall_m),
    .read_data_m    (read_data_m),
    .reg_write_ok_m (reg_write_ok_m),
    .fault_m        (fault_m),
    .fault_tid_m    (fault_tid_m),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic nop();
    reg_write_m = 0; mem_write_m = 0; result_src_m = 2'b00; funct3_m = 3'b000;
    alu_result_m = '0; write_data_m = '0; tid_m = '0; dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [2:0] tid);
    reg_write_m = 1; mem_write_m = 0; result_src_m = 2'b01; funct3_m = f3;
    alu_result_m = a; write_data_m = '0; tid_m = tid;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    reg_write_m = 0; mem_write_m = 1; result_src_m = 2'b00; funct3_m = f3;
    alu_result_m = a; write_data_m = d; tid_m = 3'd1;
  endtask

  initial begin
    nop();
    clr = 1;
    cyc(); cyc();
    clr = 0;
    settle();
    check("rst_read_data", read_data_m, 32'h0);
    check("rst_fault", {31'b0, fault_m}, 32'h0);
    check("rst_fault_tid", {29'b0, fault_tid_m}, 32'h0);
    check("idle_req", {31'b0, dmem_req}, 32'h0);
    check("idle_stall", {31'b0, stall_m}, 32'h0);
    check("idle_addr", dmem_addr, 32'h0);

    // sb 0x1003, zero-wait
    cyc(); store(3'b000, 32'h0000_1003, 32'h0000_00AB); dmem_ack = 1; settle();
    check("sb_req", {31'b0, dmem_req}, 32'h1);
    check("sb_we", {31'b0, dmem_we}, 32'h1);
    check("sb_addr", dmem_addr, 32'h0000_1000);
    check("sb_strb", {28'b0, dmem_wstrb}, 32'h8);
    check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    check("sb_stall0", {31'b0, stall_m}, 32'h1);
    cyc(); dmem_ack = 0; settle();
    check("sb_done_stall", {31'b0, stall_m}, 32'h0);
    check("sb_done_req", {31'b0, dmem_req}, 32'h0);
    check("sb_read_data", read_data_m, 32'h0);

    // lh 0x2002, ack 3 cycles after the request
    cyc(); load(3'b001, 32'h0000_2002, 3'd2); stalls = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3); dmem_rdata = (i == 3) ? 32'h8001_1234 : 32'h0;
      settle();
      if (stall_m) stalls++;
      check("lh_req", {31'b0, dmem_req}, 32'h1);
      cyc();
    end
    dmem_ack = 0; dmem_rdata = '0; settle();
    check("lh_stall_cycles", stalls, 32'd4);
    check("lh_done_stall", {31'b0, stall_m}, 32'h0);
    check("lh_read_data", read_data_m, 32'hFFFF_8001);

    // lbu 0x2001, zero-wait
    cyc(); load(3'b100, 32'h0000_2001, 3'd3); dmem_ack = 1; dmem_rdata = 32'h0000_F200; settle();
    check("lbu_stall", {31'b0, stall_m}, 32'h1);
    check("lbu_we", {31'b0, dmem_we}, 32'h0);
    check("lbu_addr", dmem_addr, 32'h0000_2000);
    cyc(); dmem_ack = 0; settle();
    check("lbu_read_data", read_data_m, 32'h0000_00F2);
    check("lbu_reg_write_ok", {31'b0, reg_write_ok_m}, 32'h1);

    // lb 0x0007 sign-extends the top byte
    cyc(); load(3'b000, 32'h0000_0007, 3'd3); dmem_ack = 1; dmem_rdata = 32'h80FF_0000; settle();
    cyc(); dmem_ack = 0; settle();
    check("lb_read_data", read_data_m, 32'hFFFF_FF80);

    // sh 0x1002, zero-wait; load data must be held
    cyc(); store(3'b001, 32'h0000_1002, 32'h5555_1234); dmem_ack = 1; settle();
    check("sh_strb", {28'b0, dmem_wstrb}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    cyc(); dmem_ack = 0; settle();
    check("sh_read_data_held", read_data_m, 32'hFFFF_FF80);

    // misaligned lw with tid 5
    cyc(); load(3'b010, 32'h0000_3002, 3'd5); settle();
    check("lw_fault_req", {31'b0, dmem_req}, 32'h0);
    check("lw_fault_stall", {31'b0, stall_m}, 32'h0);
    check("lw_fault_ok", {31'b0, reg_write_ok_m}, 32'h0);
    cyc(); nop(); settle();
    check("lw_fault_pulse", {31'b0, fault_m}, 32'h1);
    check("lw_fault_tid", {29'b0, fault_tid_m}, 32'h5);
    cyc(); settle();
    check("lw_fault_end", {31'b0, fault_m}, 32'h0);

    // store with illegal funct3
    cyc(); store(3'b011, 32'h0000_1000, 32'h1); settle();
    check("sill_req", {31'b0, dmem_req}, 32'h0);
    cyc(); nop(); settle();
    check("sill_fault", {31'b0, fault_m}, 32'h1);

    // sw flushed in its 2nd WAIT cycle, late ack ignored
    cyc(); store(3'b010, 32'h0000_4000, 32'hDEAD_BEEF); settle();
    check("sw_req", {31'b0, dmem_req}, 32'h1);
    check("sw_strb", {28'b0, dmem_wstrb}, 32'hF);
    cyc(); settle();
    cyc(); clr = 1; settle();
    check("clr_req_drop", {31'b0, dmem_req}, 32'h0);
    cyc(); clr = 0; nop(); dmem_ack = 1; dmem_rdata = 32'h1234_5678; settle();
    check("late_ack_req", {31'b0, dmem_req}, 32'h0);
    check("late_ack_stall", {31'b0, stall_m}, 32'h0);
    cyc(); dmem_ack = 0; settle();
    check("clr_read_data", read_data_m, 32'h0);
    load(3'b010, 32'h0000_5000, 3'd0); settle();
    check("clr_state_idle", {31'b0, stall_m}, 32'h1);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    cyc(); dmem_ack = 0; settle();
    check("lw_read_data", read_data_m, 32'hCAFE_F00D);

    // ALU instruction writing rd
    cyc(); nop(); reg_write_m = 1; alu_result_m = 32'h0000_1001; settle();
    check("alu_req", {31'b0, dmem_req}, 32'h0);
    check("alu_stall", {31'b0, stall_m}, 32'h0);
    check("alu_ok", {31'b0, reg_write_ok_m}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
